// File: rtl/sensor_scan_scheduler.sv
// ---------------------------------------------------------------------------
// sensor_scan_scheduler
//
// Round-robin scheduler for up to four ultrasonic range sensors. One sensor
// at a time is fired, its echo pulse is timed and converted to centimetres,
// and a single tagged result is handed downstream over valid/ready. A
// hold-off gap after every handshake keeps one sensor's ping from being
// heard by the next one. One clock cycle is 1 us.
//
// Ports
//   i_clk           clock (1 MHz)
//   i_reset         synchronous, active-high reset
//   i_enable        run scanning
//   i_sensor_mask   1 = sensor takes part in the scan (sampled only at SELECT)
//   i_echo          asynchronous echo inputs, one per sensor
//   o_trigger       trigger outputs, at most one high at a time
//   o_result_valid  result available
//   i_result_ready  consumer accepts the result
//   o_result_id     sensor index of the result
//   o_result_cm     distance in cm
//   o_result_err    00 ok, 01 too close, 10 timeout / no echo
//   o_busy          high in every state except IDLE
// ---------------------------------------------------------------------------
module sensor_scan_scheduler #(
   parameter int N_SENS          = 4,
   parameter int TRIG_CYCLES     = 10,
   parameter int TIMEOUT_CYCLES  = 23200,
   parameter int MIN_ECHO_CYCLES = 116,
   parameter int CM_DIV          = 58,
   parameter int HOLDOFF_CYCLES  = 25000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic [N_SENS-1:0] i_sensor_mask,
   input  logic [N_SENS-1:0] i_echo,
   output logic [N_SENS-1:0] o_trigger,
   output logic              o_result_valid,
   input  logic              i_result_ready,
   output logic [1:0]        o_result_id,
   output logic [8:0]        o_result_cm,
   output logic [1:0]        o_result_err,
   output logic              o_busy
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SELECT    = 3'd1,
      S_TRIG      = 3'd2,
      S_WAIT_ECHO = 3'd3,
      S_MEASURE   = 3'd4,
      S_REPORT    = 3'd5,
      S_HOLDOFF   = 3'd6
   } state_t;

   localparam logic [16:0] TRIG_LAST    = 17'(TRIG_CYCLES - 1);
   localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0] TIMEOUT_W    = 17'(TIMEOUT_CYCLES);
   localparam logic [16:0] MIN_W        = 17'(MIN_ECHO_CYCLES);
   localparam logic [16:0] PRE_LAST     = 17'(CM_DIV - 1);
   localparam logic [16:0] HOLD_LAST    = 17'(HOLDOFF_CYCLES - 1);
   localparam logic [1:0]  LAST_ID_RST  = 2'(N_SENS - 1);
   localparam logic [1:0]  ERR_OK       = 2'b00;
   localparam logic [1:0]  ERR_CLOSE    = 2'b01;
   localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

   // Counters hold at all-ones instead of wrapping.
   function automatic logic [16:0] sat_inc17(input logic [16:0] v);
      return (v == 17'h1FFFF) ? v : v + 17'd1;
   endfunction

   function automatic logic [8:0] sat_inc9(input logic [8:0] v);
      return (v == 9'h1FF) ? v : v + 9'd1;
   endfunction

   // First set mask bit strictly after 'last', wrapping. The mask is padded to
   // four bits so absent sensors read as 0 and a mod-4 walk covers everything;
   // k = 4 lands back on 'last' itself, so a lone sensor re-picks itself.
   function automatic logic [1:0] rr_pick(input logic [N_SENS-1:0] mask,
                                          input logic [1:0]        last);
      logic [3:0] m4;
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      m4    = 4'(mask);
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && m4[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   state_t            state_q, state_d;
   logic [16:0]       timer_q, timer_d;
   logic [16:0]       width_q, width_d;
   logic [16:0]       presc_q, presc_d;
   logic [8:0]        cm_q, cm_d;
   logic [1:0]        id_q, id_d;
   logic [1:0]        last_id_q, last_id_d;
   logic [N_SENS-1:0] sync1_q, sync2_q;
   logic              echo_prev_q, echo_prev_d;
   logic [N_SENS-1:0] trig_q, trig_d;
   logic              valid_q, valid_d;
   logic [1:0]        res_id_q, res_id_d;
   logic [8:0]        res_cm_q, res_cm_d;
   logic [1:0]        res_err_q, res_err_d;
   logic              busy_q, busy_d;

   logic [3:0]        sync4;
   logic              echo_sel;
   logic              echo_rise;
   logic              echo_fall;
   logic [16:0]       width_inc;
   logic [16:0]       presc_inc;
   logic [8:0]        cm_inc;

   // Next-state, counter and output-register computation.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      width_d     = width_q;
      presc_d     = presc_q;
      cm_d        = cm_q;
      id_d        = id_q;
      last_id_d   = last_id_q;
      res_id_d    = res_id_q;
      res_cm_d    = res_cm_q;
      res_err_d   = res_err_q;

      sync4       = 4'(sync2_q);
      echo_sel    = sync4[id_q];
      echo_prev_d = echo_sel;
      echo_rise   = echo_sel & ~echo_prev_q;
      echo_fall   = ~echo_sel & echo_prev_q;

      // Values as they stand after counting the current MEASURE cycle, so the
      // falling-edge cycle (the last high cycle of the delayed echo) is included.
      width_inc = sat_inc17(width_q);
      if (presc_q == PRE_LAST) begin
         presc_inc = 17'd0;
         cm_inc    = sat_inc9(cm_q);
      end else begin
         presc_inc = sat_inc17(presc_q);
         cm_inc    = cm_q;
      end

      case (state_q)
         S_IDLE: begin
            if (i_enable && (i_sensor_mask != '0)) begin
               state_d = S_SELECT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SELECT: begin
            if (i_sensor_mask == '0) begin
               state_d = S_IDLE;
            end else begin
               id_d      = rr_pick(i_sensor_mask, last_id_q);
               last_id_d = id_d;
               timer_d   = 17'd0;
               state_d   = S_TRIG;
            end
         end
         S_TRIG: begin
            if (timer_q == TRIG_LAST) begin
               timer_d = 17'd0;
               state_d = S_WAIT_ECHO;
            end else begin
               timer_d = sat_inc17(timer_q);
            end
         end
         S_WAIT_ECHO: begin
            if (echo_rise) begin
               width_d = 17'd0;
               presc_d = 17'd0;
               cm_d    = 9'd0;
               state_d = S_MEASURE;
            end else if (timer_q == TIMEOUT_LAST) begin
               res_id_d  = id_q;
               res_cm_d  = 9'd0;
               res_err_d = ERR_TIMEOUT;
               state_d   = S_REPORT;
            end else begin
               timer_d = sat_inc17(timer_q);
            end
         end
         S_MEASURE: begin
            width_d = width_inc;
            presc_d = presc_inc;
            cm_d    = cm_inc;
            if (width_inc >= TIMEOUT_W) begin
               res_id_d  = id_q;
               res_cm_d  = 9'd0;
               res_err_d = ERR_TIMEOUT;
               state_d   = S_REPORT;
            end else if (echo_fall) begin
               res_id_d = id_q;
               if (width_inc < MIN_W) begin
                  res_cm_d  = 9'd0;
                  res_err_d = ERR_CLOSE;
               end else begin
                  res_cm_d  = cm_inc;
                  res_err_d = ERR_OK;
               end
               state_d = S_REPORT;
            end else begin
               state_d = S_MEASURE;
            end
         end
         S_REPORT: begin
            if (i_result_ready) begin
               timer_d = 17'd0;
               state_d = S_HOLDOFF;
            end else begin
               state_d = S_REPORT;
            end
         end
         S_HOLDOFF: begin
            if (timer_q == HOLD_LAST) begin
               if (i_enable && (i_sensor_mask != '0)) begin
                  state_d = S_SELECT;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = sat_inc17(timer_q);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      if (state_d == S_TRIG) begin
         trig_d = {{(N_SENS-1){1'b0}}, 1'b1} << id_d;
      end else begin
         trig_d = '0;
      end
      valid_d = (state_d == S_REPORT);
      busy_d  = (state_d != S_IDLE);
   end

   // State, counters, echo synchronizer and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         timer_q     <= 17'd0;
         width_q     <= 17'd0;
         presc_q     <= 17'd0;
         cm_q        <= 9'd0;
         id_q        <= 2'd0;
         last_id_q   <= LAST_ID_RST;
         sync1_q     <= '0;
         sync2_q     <= '0;
         echo_prev_q <= 1'b0;
         trig_q      <= '0;
         valid_q     <= 1'b0;
         res_id_q    <= 2'd0;
         res_cm_q    <= 9'd0;
         res_err_q   <= 2'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         width_q     <= width_d;
         presc_q     <= presc_d;
         cm_q        <= cm_d;
         id_q        <= id_d;
         last_id_q   <= last_id_d;
         sync1_q     <= i_echo;
         sync2_q     <= sync1_q;
         echo_prev_q <= echo_prev_d;
         trig_q      <= trig_d;
         valid_q     <= valid_d;
         res_id_q    <= res_id_d;
         res_cm_q    <= res_cm_d;
         res_err_q   <= res_err_d;
         busy_q      <= busy_d;
      end
   end

   assign o_trigger      = trig_q;
   assign o_result_valid = valid_q;
   assign o_result_id    = res_id_q;
   assign o_result_cm    = res_cm_q;
   assign o_result_err   = res_err_q;
   assign o_busy         = busy_q;

endmodule
